dmem_mmio_bridge: RTL

Sits directly downstream of the processor's dmem port and upstream of the dmem syncram. Decodes each data-memory access: the top 16 words of the 12-bit space are memory-mapped I/O (LED register, cycle counter, byte TX FIFO, status); all other addresses pass through to dmem unchanged. Read data returns with the same 1-cycle registered latency as dmem, so the processor sees one uniform memory.

---
 rtl/mmio_pkg.sv | 12 +
 rtl/mmio_tx_fifo.sv | 40 ++++
 rtl/dmem_mmio_bridge.sv | 86 ++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, status bit positions and default window base for the dmem MMIO bridge.
package mmio_pkg;
    localparam logic [11:0] DEF_MMIO_BASE = 12'hFF0;
    localparam logic [3:0] OFF_LED = 4'd0;
    localparam logic [3:0] OFF_CYCLE = 4'd1;
    localparam logic [3:0] OFF_TXDATA = 4'd2;
    localparam logic [3:0] OFF_STATUS = 4'd3;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVF = 2;
    localparam int ST_COUNT = 4;
endpackage

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: circular byte buffer feeding the TX consumer; a pop frees a slot for a push on the same edge.
module mmio_tx_fifo #(
    parameter int DEPTH = 8
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] cnt;
    logic do_pop, do_push;
    assign empty = cnt == '0;
    assign full = cnt == (AW+1)'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout = empty ? 8'h00 : mem[rd_ptr];
    assign count = 4'(cnt);
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: routes dmem accesses to the syncram or a 16-word MMIO window (LED, cycle, TX FIFO, status).
// Define MMIO_TX_OVF_STICKY_EN to add a sticky TX overflow flag in STATUS bit 2.
module dmem_mmio_bridge
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter logic [11:0] MMIO_BASE = DEF_MMIO_BASE
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic [15:0] led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    logic is_mmio, mmio_wr, push, pop, full, empty, ovf, sel_q;
    logic [3:0] off, count;
    logic [31:0] cycle, status, rd_val, mmio_q;
    assign is_mmio = address_dmem[11:4] == MMIO_BASE[11:4];
    assign off = address_dmem[3:0];
    assign mmio_wr = wren & is_mmio;
    assign mem_address = address_dmem;
    assign mem_data = data;
    assign mem_wren = wren & ~is_mmio;
    assign push = mmio_wr && off == OFF_TXDATA;
    assign tx_valid = ~empty;
    assign pop = tx_valid & tx_ready;
    mmio_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(data[7:0]),
        .dout(tx_data),
        .full(full),
        .empty(empty),
        .count(count)
    );
`ifdef MMIO_TX_OVF_STICKY_EN
    logic ovf_q, drop, clr_ovf;
    assign drop = push & full & ~pop;
    assign clr_ovf = mmio_wr && off == OFF_STATUS && data[ST_OVF];
    always_ff @(posedge clock) begin
        if (reset) ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
        else if (clr_ovf) ovf_q <= 1'b0;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
    always_comb begin
        status = '0;
        status[ST_COUNT +: 4] = count;
        status[ST_OVF] = ovf;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
    end
    always_comb
        rd_val = off == OFF_LED    ? {16'h0, led} :
                 off == OFF_CYCLE  ? cycle :
                 off == OFF_STATUS ? status : '0;
    // Registered MMIO read path mirrors the syncram's one-cycle latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
            cycle <= '0;
            sel_q <= 1'b0;
            mmio_q <= '0;
        end else begin
            if (mmio_wr && off == OFF_LED) led <= data[15:0];
            cycle <= (mmio_wr && off == OFF_CYCLE) ? '0 : cycle + 32'd1;
            sel_q <= is_mmio;
            mmio_q <= rd_val;
        end
    end
    assign q_dmem = sel_q ? mmio_q : mem_q;
endmodule
